motor_cmd_ramp: RTL and testbench
=================================

MOTOR_CMD_RAMP -- requirements
Module: motor_cmd_ramp

Interface
REQ-001 Parameter K_PWMRES SHALL default to 10 and set the PWM magnitude width.
REQ-002 i_clk  in  1  master clock; all logic SHALL run on its rising edge.
REQ-003 i_rst  in  1  reset, synchronous and active-high.
REQ-004 i_target  in  K_PWMRES+1  signed two's-complement speed request; negative means reverse.
REQ-005 i_target_valid  in  1  when high, the block SHALL latch i_target at the clock edge.
REQ-006 i_brake_req  in  1  emergency brake request, level-sensitive.
REQ-007 i_param_step  in  K_PWMRES  magnitude change applied per ramp tick.
REQ-008 i_param_prescale  in  16  ramp tick period, in clocks, minus one.
REQ-009 i_param_dwell  in  16  clocks to hold the brake during a direction reversal.
REQ-010 i_param_pwm_max  in  K_PWMRES  magnitude clamp.
REQ-011 o_pwm_command  out  K_PWMRES  registered PWM magnitude for the motor control stage.
REQ-012 o_reverse  out  1  registered direction to the motor control stage.
REQ-013 o_brake  out  1  registered brake to the motor control stage.
REQ-014 o_settled  out  1  high when the state is RUN, o_pwm_command equals tgt_mag and o_reverse equals tgt_dir.

Function
REQ-015 Target decode SHALL be combinational from the latched target and the current i_param_pwm_max.
- tgt_mag = min(|target|, i_param_pwm_max).
- |most-negative| SHALL saturate to 2^K_PWMRES-1 before the clamp.
- tgt_dir = sign bit of the target.
REQ-016 Prescaler behaviour:
- counts 0..i_param_prescale and wraps to 0;
- asserts tick for one cycle at wrap;
- prescale 0 SHALL give a tick every cycle;
- free-running in every state.
REQ-017 The FSM SHALL have three states: RUN, DWELL and BRAKE.
REQ-018 RUN with o_reverse equal to tgt_dir or tgt_mag equal to 0, on each tick:
- move the magnitude toward tgt_mag by i_param_step;
- if the remaining difference is at most step, load tgt_mag exactly (no overshoot).
REQ-019 RUN with o_reverse different from tgt_dir and tgt_mag nonzero, on each tick:
- ramp the magnitude down toward 0 by step, with the same no-overshoot rule;
- in the cycle the magnitude becomes 0, enter DWELL and clear the dwell counter.
REQ-020 DWELL:
- o_pwm_command=0 and o_brake=1;
- the counter increments every clock;
- when it equals i_param_dwell, go to RUN, set o_reverse=tgt_dir and o_brake=0;
- i_param_dwell=0 SHALL give exactly one DWELL cycle.
REQ-021 A target change during DWELL SHALL NOT abort the dwell; the direction applied on exit SHALL be the latest tgt_dir.
REQ-022 i_brake_req=1 SHALL force BRAKE from any state, with priority over ticks and dwell completion.
- The next cycle SHALL show o_pwm_command=0 and o_brake=1.
REQ-023 BRAKE SHALL be held while i_brake_req=1; on deassertion go to RUN with magnitude 0, o_brake=0 and o_reverse=tgt_dir.
REQ-024 i_param_step=0 SHALL freeze the magnitude in RUN; DWELL and BRAKE SHALL be unaffected.
REQ-025 Lowering i_param_pwm_max below the current magnitude SHALL cause a ramp down at step per tick, not a jump.
REQ-026 Latching a new target SHALL NOT reset the prescaler; the first magnitude change SHALL occur at the next tick.
REQ-027 Magnitude arithmetic SHALL use K_PWMRES+1 bits internally, so add and subtract never wrap.

Reset
REQ-028 While i_rst is high, at every edge the block SHALL set:
- latched target=0, magnitude=0, o_reverse=0, o_brake=0;
- state=RUN, prescaler=0, dwell counter=0.
REQ-029 o_settled SHALL read 1 after reset; a reset asserted mid-DWELL or mid-BRAKE SHALL take effect at the next edge with no residual brake.

Structure
REQ-030 Package motor_pkg SHALL hold the FSM state enum and the default K_PWMRES constant.
REQ-031 The prescaler SHALL be a sub-module, tick_prescaler (16-bit period input, one-cycle tick output, same clock and reset); the remaining logic SHALL stay in motor_cmd_ramp.

Verification
All scenarios use K_PWMRES=10 unless noted.
REQ-032 step=4, prescale=9, target +100 from reset -> o_pwm_command rises 4 per 10 clocks, reaches 100 after 25 ticks, o_settled=1, o_reverse=0.
REQ-033 From +100 settled, target -40, dwell=50 -> ramp to 0 in 25 ticks, then o_brake=1 for 51 cycles, then o_reverse=1 and ramp to 40 (values 4..40).
REQ-034 step=4, target +10 -> sequence 4, 8, 10, then hold; no overshoot.
REQ-035 i_brake_req pulsed mid-ramp at magnitude 60 -> next cycle pwm=0 and o_brake=1; after release, ramp restarts from 0 in the same direction.
REQ-036 pwm_max=300, target -512 -> settles at 300 with o_reverse=1; then pwm_max=200 -> ramps down to 200 at step per tick.
REQ-037 i_rst asserted during DWELL -> next cycle all outputs 0 except o_settled=1; state RUN.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared definitions for the motor command ramp: FSM state encoding and default PWM width.
package motor_pkg;
  localparam int K_PWMRES_DEF = 10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWELL = 2'd1,
    ST_BRAKE = 2'd2
  } motor_state_e;
endpackage

// File: rtl/motor_cmd_ramp_if.sv
// Command/parameter bundle between the speed controller (master) and the ramp block (slave).
interface motor_cmd_ramp_if
  import motor_pkg::*;
#(
  parameter int K_PWMRES = K_PWMRES_DEF
);
  logic signed [K_PWMRES:0]   i_target;
  logic                       i_target_valid;
  logic                       i_brake_req;
  logic        [K_PWMRES-1:0] i_param_step;
  logic        [15:0]         i_param_prescale;
  logic        [15:0]         i_param_dwell;
  logic        [K_PWMRES-1:0] i_param_pwm_max;
  logic        [K_PWMRES-1:0] o_pwm_command;
  logic                       o_reverse;
  logic                       o_brake;
  logic                       o_settled;

  modport master (
    output i_target, i_target_valid, i_brake_req, i_param_step,
           i_param_prescale, i_param_dwell, i_param_pwm_max,
    input  o_pwm_command, o_reverse, o_brake, o_settled
  );

  modport slave (
    input  i_target, i_target_valid, i_brake_req, i_param_step,
           i_param_prescale, i_param_dwell, i_param_pwm_max,
    output o_pwm_command, o_reverse, o_brake, o_settled
  );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running ramp tick generator: counts 0..i_period, tick high in the wrap cycle.
module tick_prescaler (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_period,
  output logic        o_tick
);
  logic [15:0] cnt;

  // >= so a period lowered below the running count wraps immediately
  assign o_tick = (cnt >= i_period);

  always_ff @(posedge i_clk) begin
    if (i_rst)       cnt <= '0;
    else if (o_tick) cnt <= '0;
    else             cnt <= cnt + 16'd1;
  end
endmodule

// File: rtl/motor_cmd_ramp.sv
// Slew-limited PWM command generator with brake-and-dwell direction reversal and emergency brake.
module motor_cmd_ramp
  import motor_pkg::*;
#(
  parameter int K_PWMRES = K_PWMRES_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  motor_cmd_ramp_if.slave mif
);
  localparam int W = K_PWMRES;

  motor_state_e      state;
  logic signed [W:0] tgt;
  logic [W-1:0]      mag, tgt_abs, tgt_mag, nxt_toward, nxt_down;
  logic [W:0]        magx, tgtx, stepx, d_up, d_dn;
  logic [15:0]       dcnt;
  logic              tgt_dir, rev, brk, tick;

  tick_prescaler u_presc (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_period (mif.i_param_prescale),
    .o_tick   (tick)
  );

  always_comb begin
    tgt_dir = tgt[W];
    // the most-negative request has no positive twin; pin it to full scale
    if (tgt == {1'b1, {W{1'b0}}}) tgt_abs = '1;
    else if (tgt_dir)             tgt_abs = W'(-tgt);
    else                          tgt_abs = W'(tgt);
    tgt_mag = (tgt_abs > mif.i_param_pwm_max) ? mif.i_param_pwm_max : tgt_abs;

    magx  = {1'b0, mag};
    tgtx  = {1'b0, tgt_mag};
    stepx = {1'b0, mif.i_param_step};
    d_up  = tgtx - magx;
    d_dn  = magx - tgtx;

    nxt_toward = mag;
    if (magx < tgtx)      nxt_toward = (d_up <= stepx) ? tgt_mag : mag + mif.i_param_step;
    else if (magx > tgtx) nxt_toward = (d_dn <= stepx) ? tgt_mag : mag - mif.i_param_step;
    nxt_down = (magx <= stepx) ? '0 : mag - mif.i_param_step;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tgt   <= '0;
      mag   <= '0;
      rev   <= 1'b0;
      brk   <= 1'b0;
      state <= ST_RUN;
      dcnt  <= '0;
    end else begin
      if (mif.i_target_valid) tgt <= mif.i_target;
      if (mif.i_brake_req) begin
        state <= ST_BRAKE;
        mag   <= '0;
        brk   <= 1'b1;
      end else begin
        case (state)
          ST_RUN: if (tick) begin
            if (rev == tgt_dir || tgt_mag == '0) begin
              mag <= nxt_toward;
            end else begin
              // wrong direction: spin down, then brake for the dwell before flipping
              mag <= nxt_down;
              if (nxt_down == '0) begin
                state <= ST_DWELL;
                dcnt  <= '0;
                brk   <= 1'b1;
              end
            end
          end
          ST_DWELL: begin
            mag <= '0;
            if (dcnt == mif.i_param_dwell) begin
              state <= ST_RUN;
              rev   <= tgt_dir;
              brk   <= 1'b0;
            end else begin
              dcnt <= dcnt + 16'd1;
            end
          end
          default: begin
            state <= ST_RUN;
            mag   <= '0;
            brk   <= 1'b0;
            rev   <= tgt_dir;
          end
        endcase
      end
    end
  end

  assign mif.o_pwm_command = mag;
  assign mif.o_reverse     = rev;
  assign mif.o_brake       = brk;
  assign mif.o_settled     = (state == ST_RUN) && (mag == tgt_mag) && (rev == tgt_dir);
endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Directed bench for motor_cmd_ramp: ramp, reversal dwell, clamp, brake and reset cases.
module tb_motor_cmd_ramp;
  logic clk, rst;
  int   checks = 0;
  int   errors = 0;
  int   n;

  motor_cmd_ramp_if #(.K_PWMRES(10)) mif ();

  motor_cmd_ramp #(.K_PWMRES(10)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .mif   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic latch(input logic signed [10:0] t);
    mif.i_target       = t;
    mif.i_target_valid = 1'b1;
    cyc(1);
    mif.i_target_valid = 1'b0;
  endtask

  initial begin
    rst                  = 1'b1;
    mif.i_target         = '0;
    mif.i_target_valid   = 1'b0;
    mif.i_brake_req      = 1'b0;
    mif.i_param_step     = 10'd4;
    mif.i_param_prescale = 16'd9;
    mif.i_param_dwell    = 16'd50;
    mif.i_param_pwm_max  = 10'd1023;
    cyc(2);
    chk("rst_pwm", int'(mif.o_pwm_command), 0);
    chk("rst_rev", int'(mif.o_reverse), 0);
    chk("rst_brk", int'(mif.o_brake), 0);
    chk("rst_settled", int'(mif.o_settled), 1);

    // forward ramp to +100, 4 per 10 clocks
    rst = 1'b0;
    latch(11'sd100);
    cyc(8);   chk("up_e9", int'(mif.o_pwm_command), 0);
    cyc(1);   chk("up_e10", int'(mif.o_pwm_command), 4);
    cyc(10);  chk("up_e20", int'(mif.o_pwm_command), 8);
    cyc(229); chk("up_e249", int'(mif.o_pwm_command), 96);
              chk("up_e249_settled", int'(mif.o_settled), 0);
    cyc(1);   chk("up_e250", int'(mif.o_pwm_command), 100);
              chk("up_settled", int'(mif.o_settled), 1);
              chk("up_rev", int'(mif.o_reverse), 0);

    // reversal to -40 with 50-clock dwell
    latch(-11'sd40);
    cyc(8);   chk("rv_e259", int'(mif.o_pwm_command), 100);
    cyc(1);   chk("rv_e260", int'(mif.o_pwm_command), 96);
    cyc(239); chk("rv_e499", int'(mif.o_pwm_command), 4);
              chk("rv_e499_brk", int'(mif.o_brake), 0);
    cyc(1);   chk("rv_e500", int'(mif.o_pwm_command), 0);
              chk("rv_e500_brk", int'(mif.o_brake), 1);
    n = 1;
    for (int i = 0; i < 80 && mif.o_brake; i++) begin
      cyc(1);
      if (mif.o_brake) n++;
    end
    chk("rv_dwell_len", n, 51);
    chk("rv_rev", int'(mif.o_reverse), 1);
    cyc(9);   chk("rv_first", int'(mif.o_pwm_command), 4);
    cyc(90);  chk("rv_end", int'(mif.o_pwm_command), 40);
              chk("rv_settled", int'(mif.o_settled), 1);

    // small target: 4, 8, 10, hold; then step 0 freezes
    rst = 1'b1; cyc(1); rst = 1'b0;
    latch(11'sd10);
    cyc(9);  chk("sm_4", int'(mif.o_pwm_command), 4);
    cyc(10); chk("sm_8", int'(mif.o_pwm_command), 8);
    cyc(10); chk("sm_10", int'(mif.o_pwm_command), 10);
    cyc(10); chk("sm_hold", int'(mif.o_pwm_command), 10);
             chk("sm_settled", int'(mif.o_settled), 1);
    mif.i_param_step = 10'd0;
    latch(11'sd50);
    cyc(30); chk("step0_freeze", int'(mif.o_pwm_command), 10);
             chk("step0_settled", int'(mif.o_settled), 0);

    // emergency brake at magnitude 60
    rst = 1'b1; cyc(1); rst = 1'b0;
    mif.i_param_step = 10'd4;
    latch(11'sd100);
    cyc(149); chk("bk_60", int'(mif.o_pwm_command), 60);
    mif.i_brake_req = 1'b1;
    cyc(1);  chk("bk_pwm", int'(mif.o_pwm_command), 0);
             chk("bk_brk", int'(mif.o_brake), 1);
    cyc(2);  chk("bk_hold", int'(mif.o_brake), 1);
    mif.i_brake_req = 1'b0;
    cyc(1);  chk("bk_rel_brk", int'(mif.o_brake), 0);
             chk("bk_rel_rev", int'(mif.o_reverse), 0);
    cyc(5);  chk("bk_rel_e159", int'(mif.o_pwm_command), 0);
    cyc(1);  chk("bk_restart", int'(mif.o_pwm_command), 4);

    // clamp: target -512 limited to 300, then 200; then most-negative target
    rst = 1'b1; cyc(1); rst = 1'b0;
    mif.i_param_prescale = 16'd0;
    mif.i_param_step     = 10'd20;
    mif.i_param_dwell    = 16'd0;
    mif.i_param_pwm_max  = 10'd300;
    latch(-11'sd512);
    cyc(1);  chk("cl_dwell_brk", int'(mif.o_brake), 1);
    cyc(1);  chk("cl_exit_brk", int'(mif.o_brake), 0);
             chk("cl_exit_rev", int'(mif.o_reverse), 1);
    cyc(1);  chk("cl_20", int'(mif.o_pwm_command), 20);
    cyc(14); chk("cl_300", int'(mif.o_pwm_command), 300);
             chk("cl_settled", int'(mif.o_settled), 1);
    mif.i_param_pwm_max = 10'd200;
    cyc(1);  chk("cl_280", int'(mif.o_pwm_command), 280);
    cyc(3);  chk("cl_220", int'(mif.o_pwm_command), 220);
    cyc(1);  chk("cl_200", int'(mif.o_pwm_command), 200);
    cyc(1);  chk("cl_200_hold", int'(mif.o_pwm_command), 200);
    mif.i_param_pwm_max = 10'd1023;
    latch(11'h400);
    cyc(50); chk("mn_sat", int'(mif.o_pwm_command), 1023);
             chk("mn_settled", int'(mif.o_settled), 1);

    // reset while dwelling
    mif.i_param_dwell = 16'd20;
    latch(11'sd5);
    n = 0;
    while (!mif.o_brake && n < 200) begin
      cyc(1);
      n++;
    end
    chk("rd_enter", int'(mif.o_brake), 1);
    cyc(3);  chk("rd_mid_brk", int'(mif.o_brake), 1);
    rst = 1'b1;
    cyc(1);  chk("rd_pwm", int'(mif.o_pwm_command), 0);
             chk("rd_rev", int'(mif.o_reverse), 0);
             chk("rd_brk", int'(mif.o_brake), 0);
             chk("rd_settled", int'(mif.o_settled), 1);
    rst = 1'b0;
    cyc(3);  chk("rd_after_brk", int'(mif.o_brake), 0);
             chk("rd_after_settled", int'(mif.o_settled), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
